// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: free-running pixel/line counters with sync, blanking,
// line/frame strobes and a frame counter, plus PIPE_DLY-delayed copies of the syncs and de.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter int unsigned PIPE_DLY = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [10:0] vga_x,
  output logic [10:0] vga_y,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        line_start,
  output logic        frame_start,
  output logic [7:0]  frame_cnt,
  output logic        hsync_d,
  output logic        vsync_d,
  output logic        de_d
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_ACTIVE);
  localparam logic [10:0] V_VIS  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        act_q, act_d;
  logic        ls_q, ls_d;
  logic        fs_q, fs_d;
  logic [7:0]  fc_q, fc_d;

  // Strobes are decoded from the next count so they land in the same cycle as that count.
  always_comb begin
    x_d = x_q + 11'd1;
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + 11'd1;
    end
    hs_d  = !((x_d >= HS_BEG) && (x_d < HS_END));
    vs_d  = !((y_d >= VS_BEG) && (y_d < VS_END));
    act_d = (x_d < H_VIS) && (y_d < V_VIS);
    ls_d  = (x_d == '0);
    fs_d  = ls_d && (y_d == '0);
    fc_d  = fs_d ? fc_q + 8'd1 : fc_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      act_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
      fc_q  <= '0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      act_q <= act_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
      fc_q  <= fc_d;
    end
  end

  assign vga_x       = x_q;
  assign vga_y       = y_q;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = act_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign frame_cnt   = fc_q;

  generate
    if (PIPE_DLY == 0) begin : g_nodly
      assign hsync_d = hs_q;
      assign vsync_d = vs_q;
      assign de_d    = act_q;
    end else begin : g_dly
      logic [PIPE_DLY-1:0] hs_sr_q, vs_sr_q, de_sr_q;
      logic [PIPE_DLY:0]   hs_tap, vs_tap, de_tap;

      // Tap 0 is the live signal; stage k loads tap k, i.e. stage k-1.
      assign hs_tap = {hs_sr_q, hs_q};
      assign vs_tap = {vs_sr_q, vs_q};
      assign de_tap = {de_sr_q, act_q};

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          hs_sr_q <= '1;
          vs_sr_q <= '1;
          de_sr_q <= '0;
        end else begin
          hs_sr_q <= hs_tap[PIPE_DLY-1:0];
          vs_sr_q <= vs_tap[PIPE_DLY-1:0];
          de_sr_q <= de_tap[PIPE_DLY-1:0];
        end
      end

      assign hsync_d = hs_sr_q[PIPE_DLY-1];
      assign vsync_d = vs_sr_q[PIPE_DLY-1];
      assign de_d    = de_sr_q[PIPE_DLY-1];
    end
  endgenerate

endmodule
